// File: rtl/store_write_buffer.sv
// Store write buffer: aligns formatted store data to byte lanes, queues
// stores in a small FIFO and drains them in order over a req/ack handshake.
// Flags illegal/misaligned stores and pending-store hazards for loads.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_size,
  output logic          st_err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          empty
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [3:0] {
    SZ_WORD = 4'b0000,
    SZ_BYTE = 4'b0010,
    SZ_HALF = 4'b0100
  } size_e;

  logic [AW-3:0]    word_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             err_q;

  logic             legal, handshake, push, pop, hazard;
  logic [1:0]       off;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_data;
  logic             unused_ld_off;

  assign st_ready  = (count != FULL_CNT);
  assign empty     = (count == '0);
  assign mem_req   = !empty;
  assign handshake = st_valid && st_ready;
  assign push      = handshake && legal;
  assign pop       = mem_req && mem_ack;
  assign st_err    = err_q;
  assign ld_hazard = hazard;

  assign mem_addr  = mem_req ? {word_q[rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_req ? data_q[rd_ptr] : '0;
  assign mem_be    = mem_req ? be_q[rd_ptr] : '0;

  // Load hazards compare word addresses only; byte offset is irrelevant.
  assign unused_ld_off = ^ld_addr[1:0];

  // Legality check and byte-lane placement of the incoming store.
  always_comb begin
    off      = st_addr[1:0];
    legal    = 1'b0;
    fmt_be   = '0;
    fmt_data = '0;
    case (st_size)
      SZ_BYTE: begin
        legal    = 1'b1;
        fmt_be   = 4'b0001 << off;
        fmt_data = {24'b0, st_data[7:0]} << {off, 3'b000};
      end
      SZ_HALF: begin
        legal    = !st_addr[0];
        fmt_be   = 4'b0011 << off;
        fmt_data = {16'b0, st_data[15:0]} << {off, 3'b000};
      end
      SZ_WORD: begin
        legal    = (off == 2'b00);
        fmt_be   = 4'b1111;
        fmt_data = st_data;
      end
      default: legal = 1'b0;
    endcase
  end

  // Any valid entry targeting the load's word raises a hazard.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[PW'(i)] && (word_q[PW'(i)] == ld_addr[AW-1:2])) hazard = 1'b1;
    end
  end

  // Pointer, occupancy and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= handshake && !legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; push and pop never touch the same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[PW'(i)] <= '0;
        data_q[PW'(i)] <= '0;
        be_q[PW'(i)]   <= '0;
      end
    end else begin
      if (pop) valid_q[rd_ptr] <= 1'b0;
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        word_q[wr_ptr]  <= st_addr[AW-1:2];
        data_q[wr_ptr]  <= fmt_data;
        be_q[wr_ptr]    <= fmt_be;
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_store_write_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_size;
  logic          st_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;
  logic          empty;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_err(st_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic err_exp;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_legal(input logic [3:0] sz, input logic [31:0] a);
    if (sz == 4'd2) return 1'b1;
    if (sz == 4'd4) return (a % 2) == 0;
    if (sz == 4'd0) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic ent_t make_ent(input logic [3:0] sz, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int unsigned o;
    o = a % 4;
    e.addr = a - o;
    if (sz == 4'd2) begin
      e.be   = 4'(1 << o);
      e.data = (d & 32'hFF) << (8 * o);
    end else if (sz == 4'd4) begin
      e.be   = 4'(3 << o);
      e.data = (d & 32'hFFFF) << (8 * o);
    end else begin
      e.be   = 4'hF;
      e.data = d;
    end
    return e;
  endfunction

  function automatic bit model_hazard(input logic [31:0] la);
    foreach (q[i]) if (q[i].addr == (la & ~32'd3)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check combinational outputs, then advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sz, input logic ack, input logic [31:0] la);
    bit acc, pop;
    @(negedge clk);
    check("st_err", st_err, err_exp);
    st_valid = v; st_addr = a; st_data = d; st_size = sz; mem_ack = ack; ld_addr = la;
    #1;
    check("st_ready",  st_ready, q.size() != DEPTH);
    check("empty",     empty, q.size() == 0);
    check("mem_req",   mem_req, q.size() != 0);
    check("mem_addr",  mem_addr,  q.size() != 0 ? q[0].addr : 32'd0);
    check("mem_wdata", mem_wdata, q.size() != 0 ? q[0].data : 32'd0);
    check("mem_be",    mem_be,    q.size() != 0 ? q[0].be   : 4'd0);
    check("ld_hazard", ld_hazard, model_hazard(la));
    acc = v && (q.size() != DEPTH);
    pop = ack && (q.size() != 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && is_legal(sz, a)) q.push_back(make_ent(sz, a, d));
    err_exp = acc && !is_legal(sz, a);
  endtask

  task automatic idle(input logic ack, input logic [31:0] la);
    step(1'b0, 32'd0, 32'd0, 4'd0, ack, la);
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    mem_ack = 1'b0; ld_addr = '0; err_exp = 1'b0;
    #12;
    check("rst_req",   mem_req, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_ready", st_ready, 1'b1);
    check("rst_err",   st_err, 1'b0);
    check("rst_be",    mem_be, 4'd0);
    check("rst_haz",   ld_hazard, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Word store then drain.
    step(1, 32'h100, 32'hDEADBEEF, 4'd0, 0, 32'h0);
    idle(1, 32'h0);
    idle(0, 32'h0);

    // Byte lanes, filling the buffer, then draining in order.
    step(1, 32'h203, 32'hAA, 4'd2, 0, 32'h0);
    step(1, 32'h202, 32'hAA, 4'd2, 0, 32'h0);
    step(1, 32'h201, 32'hAA, 4'd2, 0, 32'h0);
    step(1, 32'h200, 32'hAA, 4'd2, 0, 32'h0);
    idle(0, 32'h0);
    repeat (4) idle(1, 32'h200);
    idle(0, 32'h0);

    // Half store, misaligned word, illegal size.
    step(1, 32'h302, 32'h1234, 4'd4, 0, 32'h0);
    idle(1, 32'h0);
    step(1, 32'h305, 32'h11111111, 4'd0, 0, 32'h0);
    idle(0, 32'h0);
    step(1, 32'h300, 32'h22222222, 4'hF, 0, 32'h0);
    idle(0, 32'h0);
    idle(0, 32'h0);

    // Full, then push attempt with ack, then push and ack together.
    for (int i = 0; i < DEPTH; i++) step(1, 32'h600 + 4*i, 32'h1000 + i, 4'd0, 0, 32'h0);
    step(1, 32'h700, 32'hBEEF0001, 4'd0, 1, 32'h0);
    step(1, 32'h704, 32'hBEEF0002, 4'd0, 1, 32'h0);
    step(1, 32'h708, 32'hBEEF0003, 4'd0, 1, 32'h0);
    repeat (DEPTH) idle(1, 32'h700);

    // Load hazard.
    step(1, 32'h404, 32'h55, 4'd2, 0, 32'h0);
    idle(0, 32'h407);
    idle(0, 32'h408);
    idle(1, 32'h404);
    idle(0, 32'h404);

    // Asynchronous reset with entries pending.
    for (int i = 0; i < 3; i++) step(1, 32'h800 + 4*i, 32'h77 + i, 4'd0, 0, 32'h800);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req",   mem_req, 1'b0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_ready", st_ready, 1'b1);
    check("mid_rst_haz",   ld_hazard, 1'b0);
    q.delete();
    err_exp = 1'b0;
    #1 rst_n = 1'b1;
    step(1, 32'h900, 32'hCAFEF00D, 4'd0, 0, 32'h800);
    idle(1, 32'h900);
    idle(1, 32'h800);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] sz;
      case ($urandom_range(0, 4))
        0: sz = 4'd0;
        1: sz = 4'd2;
        2: sz = 4'd4;
        3: sz = 4'($urandom);
        default: sz = 4'd2;
      endcase
      step(1'($urandom_range(0, 3) != 0), 32'h400 + $urandom_range(0, 15), $urandom, sz,
           1'((i / 50) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0),
           32'h400 + $urandom_range(0, 15));
    end
    repeat (DEPTH + 2) idle(1, 32'h400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
